// File: rtl/p_s_pkg.sv
// Shared constants and state encoding for the p_s parallel-to-serial stage.
package p_s_pkg;
    localparam int WORD_W     = 34;
    localparam int NUM_WORDS  = 4;
    localparam int GROUP_W    = WORD_W * NUM_WORDS;
    localparam int FIFO_DEPTH = 2;
    localparam int WCNT_W     = $clog2(NUM_WORDS);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;
endpackage

// File: rtl/p_s_fifo.sv
// Group-wide synchronous FIFO holding groups waiting for the serializer.
module p_s_fifo
    import p_s_pkg::*;
#(
    parameter int W     = GROUP_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [W-1:0]             din_i,
    output logic [W-1:0]             dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    // A push into a full FIFO is only issued together with a pop, so count stays put.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
endmodule

// File: rtl/p_s.sv
// Parallel-to-serial stage: buffers 136-bit groups from s_p and replays them
// as four 34-bit words over a valid/ready handshake.
module p_s
    import p_s_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [GROUP_W-1:0] data_in_1,
    input  logic               p_s_flag_in,
    input  logic               out_ready,
    output logic [WORD_W-1:0]  data_out_1,
    output logic               p_s_valid_out,
    output logic               p_s_last_out,
    output logic               busy_out,
    output logic               overflow_out
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [WCNT_W-1:0] LAST_IDX   = WCNT_W'(NUM_WORDS - 1);
    localparam logic [WCNT_W-1:0] PENULT_IDX = WCNT_W'(NUM_WORDS - 2);

    state_e             state_q;
    logic [GROUP_W-1:0] shift_q;
    logic [WCNT_W-1:0]  word_cnt_q;
    logic               valid_q;
    logic               last_q;
    logic               busy_q;
    logic               ovf_q;

    logic [GROUP_W-1:0] head;
    logic               full;
    logic               empty;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_d;
    logic               last_hs;
    logic               pop;
    logic               push;
    logic               shift_d;

    assign last_hs = (state_q == SHIFT) && out_ready && (word_cnt_q == LAST_IDX);
    assign pop     = !rst && !empty && ((state_q == IDLE) || last_hs);
    assign push    = !rst && p_s_flag_in && (!full || pop);
    assign shift_d = (state_q == IDLE) ? !empty : !(last_hs && empty);

    always_comb begin
        count_d = count;
        if (push && !pop)      count_d = count + CNT_W'(1);
        else if (pop && !push) count_d = count - CNT_W'(1);
    end

    p_s_fifo #(
        .W     (GROUP_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (data_in_1),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // shift_q is cleared whenever no word is presented, so its top word doubles as data_out_1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            word_cnt_q <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            busy_q <= shift_d || (count_d != '0);
            if (p_s_flag_in && full && !pop) ovf_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        state_q    <= SHIFT;
                        shift_q    <= head;
                        word_cnt_q <= '0;
                        valid_q    <= 1'b1;
                        last_q     <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (out_ready) begin
                        if (word_cnt_q == LAST_IDX) begin
                            if (!empty) begin
                                shift_q    <= head;
                                word_cnt_q <= '0;
                                last_q     <= 1'b0;
                            end else begin
                                state_q <= IDLE;
                                shift_q <= '0;
                                valid_q <= 1'b0;
                                last_q  <= 1'b0;
                            end
                        end else begin
                            shift_q    <= shift_q << WORD_W;
                            word_cnt_q <= word_cnt_q + WCNT_W'(1);
                            last_q     <= (word_cnt_q == PENULT_IDX);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out_1    = shift_q[GROUP_W-1 -: WORD_W];
    assign p_s_valid_out = valid_q;
    assign p_s_last_out  = last_q;
    assign busy_out      = busy_q;
    assign overflow_out  = ovf_q;
endmodule

// File: tb/tb_p_s.sv
// Self-checking bench for p_s: directed scenarios plus randomized traffic
// checked against a word-queue model of the serializer.
module tb_p_s;
    import p_s_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [GROUP_W-1:0] data_in_1;
    logic               p_s_flag_in;
    logic               out_ready;
    logic [WORD_W-1:0]  data_out_1;
    logic               p_s_valid_out;
    logic               p_s_last_out;
    logic               busy_out;
    logic               overflow_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    p_s dut (
        .clk           (clk),
        .rst           (rst),
        .data_in_1     (data_in_1),
        .p_s_flag_in   (p_s_flag_in),
        .out_ready     (out_ready),
        .data_out_1    (data_out_1),
        .p_s_valid_out (p_s_valid_out),
        .p_s_last_out  (p_s_last_out),
        .busy_out      (busy_out),
        .overflow_out  (overflow_out)
    );

    // Handshake log ({last, data}) and a stall-stability watcher.
    logic [WORD_W:0]   got_q[$];
    int                stab_err = 0;
    logic              pend = 1'b0;
    logic [WORD_W-1:0] pend_data;
    logic              pend_last;

    always @(negedge clk) begin
        if (pend && !(p_s_valid_out === 1'b1 && data_out_1 === pend_data && p_s_last_out === pend_last))
            stab_err++;
        if (rst === 1'b0 && p_s_valid_out === 1'b1 && out_ready === 1'b1)
            got_q.push_back({p_s_last_out, data_out_1});
        pend      = (p_s_valid_out === 1'b1) && (out_ready === 1'b0) && (rst === 1'b0);
        pend_data = data_out_1;
        pend_last = p_s_last_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; p_s_flag_in = 1'b0; out_ready = 1'b1; data_in_1 = '0;
        tick(); tick();
        rst = 1'b0;
        got_q.delete();
    endtask

    function automatic logic [GROUP_W-1:0] mk(input logic [WORD_W-1:0] w0, w1, w2, w3);
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [WORD_W-1:0] rand_word();
        logic [1:0] hi;
        hi = 2'($urandom_range(0, 3));
        return {hi, 32'($urandom())};
    endfunction

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1; p_s_flag_in = 1'b1;
        data_in_1 = mk(rand_word(), rand_word(), rand_word(), rand_word());
        tick(); tick();
        if (p_s_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", p_s_valid_out); end
        n_checks++;
        if (data_out_1 !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", data_out_1); end
        n_checks++;
        if (p_s_last_out !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", p_s_last_out); end
        n_checks++;
        if (busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_out); end
        n_checks++;
        if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow_out); end
        n_checks++;
        rst = 1'b0; p_s_flag_in = 1'b0;
        tick(); tick();
        if (p_s_valid_out !== 1'b0 || busy_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_flag_ignored: valid %b busy %b want 0 0", p_s_valid_out, busy_out);
        end
        n_checks++;
    endtask

    task automatic test_single();
        logic [WORD_W-1:0] w[4];
        apply_reset();
        for (int i = 0; i < 4; i++) w[i] = 34'(i + 1);
        data_in_1 = mk(w[0], w[1], w[2], w[3]); p_s_flag_in = 1'b1;
        tick();
        p_s_flag_in = 1'b0;
        if (p_s_valid_out !== 1'b0 || busy_out !== 1'b1) begin
            n_fail++; $display("FAIL single_latency: valid %b busy %b want 0 1", p_s_valid_out, busy_out);
        end
        n_checks++;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (p_s_valid_out !== 1'b1 || data_out_1 !== w[i] || p_s_last_out !== (i == 3)) begin
                n_fail++;
                $display("FAIL single_word%0d: valid %b data %h last %b want 1 %h %b",
                         i, p_s_valid_out, data_out_1, p_s_last_out, w[i], (i == 3));
            end
            n_checks++;
        end
        tick();
        if (p_s_valid_out !== 1'b0 || busy_out !== 1'b0 || data_out_1 !== '0) begin
            n_fail++; $display("FAIL single_idle: valid %b busy %b data %h want 0 0 0", p_s_valid_out, busy_out, data_out_1);
        end
        n_checks++;
    endtask

    task automatic test_back_to_back();
        logic [WORD_W-1:0] w[8];
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            w[i] = 34'('hA0 + i);
            w[i+4] = 34'('hB0 + i);
        end
        data_in_1 = mk(w[0], w[1], w[2], w[3]); p_s_flag_in = 1'b1;
        tick();
        data_in_1 = mk(w[4], w[5], w[6], w[7]);
        for (int i = 0; i < 8; i++) begin
            tick();
            p_s_flag_in = 1'b0;
            if (p_s_valid_out !== 1'b1 || data_out_1 !== w[i] || p_s_last_out !== (i % 4 == 3)) begin
                n_fail++;
                $display("FAIL b2b_word%0d: valid %b data %h last %b want 1 %h %b",
                         i, p_s_valid_out, data_out_1, p_s_last_out, w[i], (i % 4 == 3));
            end
            n_checks++;
        end
        tick();
        if (p_s_valid_out !== 1'b0 || overflow_out !== 1'b0) begin
            n_fail++; $display("FAIL b2b_end: valid %b ovf %b want 0 0", p_s_valid_out, overflow_out);
        end
        n_checks++;
    endtask

    task automatic test_backpressure();
        logic [WORD_W-1:0] w[4];
        apply_reset();
        for (int i = 0; i < 4; i++) w[i] = rand_word();
        stab_err = 0;
        data_in_1 = mk(w[0], w[1], w[2], w[3]); p_s_flag_in = 1'b1;
        tick();
        p_s_flag_in = 1'b0;
        tick(); tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (p_s_valid_out !== 1'b1 || data_out_1 !== w[1]) begin
                n_fail++; $display("FAIL bp_hold%0d: valid %b data %h want 1 %h", i, p_s_valid_out, data_out_1, w[1]);
            end
            n_checks++;
            tick();
        end
        out_ready = 1'b1;
        tick();
        if (p_s_valid_out !== 1'b1 || data_out_1 !== w[2]) begin
            n_fail++; $display("FAIL bp_resume: valid %b data %h want 1 %h", p_s_valid_out, data_out_1, w[2]);
        end
        n_checks++;
        tick();
        if (data_out_1 !== w[3] || p_s_last_out !== 1'b1) begin
            n_fail++; $display("FAIL bp_last: data %h last %b want %h 1", data_out_1, p_s_last_out, w[3]);
        end
        n_checks++;
        if (stab_err !== 0) begin n_fail++; $display("FAIL bp_stability: got %0d violations want 0", stab_err); end
        n_checks++;
    endtask

    task automatic test_overflow();
        logic [WORD_W-1:0] exp_q[$];
        int cyc;
        apply_reset();
        out_ready = 1'b0;
        for (int g = 1; g <= 4; g++) begin
            data_in_1 = mk(34'(g*16), 34'(g*16+1), 34'(g*16+2), 34'(g*16+3));
            if (g <= 3) for (int i = 0; i < 4; i++) exp_q.push_back(34'(g*16+i));
            p_s_flag_in = 1'b1;
            tick();
            if (g == 3 && overflow_out !== 1'b0) begin
                n_fail++; $display("FAIL ovf_early: got %b want 0", overflow_out);
            end
            if (g == 3) n_checks++;
        end
        p_s_flag_in = 1'b0;
        if (overflow_out !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", overflow_out); end
        n_checks++;
        got_q.delete();
        out_ready = 1'b1;
        cyc = 0;
        while (got_q.size() < 12 && cyc < 60) begin tick(); cyc++; end
        repeat (5) tick();
        if (got_q.size() !== 12) begin n_fail++; $display("FAIL ovf_count: got %0d words want 12", got_q.size()); end
        n_checks++;
        for (int i = 0; i < 12 && i < got_q.size(); i++) begin
            if (got_q[i] !== {(i % 4 == 3), exp_q[i]}) begin
                n_fail++; $display("FAIL ovf_word%0d: got %h want %h", i, got_q[i], {(i % 4 == 3), exp_q[i]});
            end
            n_checks++;
        end
        if (overflow_out !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow_out); end
        n_checks++;
    endtask

    task automatic test_push_pop();
        logic [WORD_W-1:0] exp_q[$];
        int cyc;
        apply_reset();
        out_ready = 1'b0;
        for (int g = 1; g <= 3; g++) begin
            data_in_1 = mk(34'(g*16+5), 34'(g*16+6), 34'(g*16+7), 34'(g*16+8));
            for (int i = 0; i < 4; i++) exp_q.push_back(34'(g*16+5+i));
            p_s_flag_in = 1'b1;
            tick();
        end
        p_s_flag_in = 1'b0;
        got_q.delete();
        out_ready = 1'b1;
        tick(); tick(); tick();
        data_in_1 = mk(34'h3_0000_0001, 34'h3_0000_0002, 34'h3_0000_0003, 34'h3_0000_0004);
        for (int i = 1; i <= 4; i++) exp_q.push_back(34'h3_0000_0000 | 34'(i));
        p_s_flag_in = 1'b1;
        tick();
        p_s_flag_in = 1'b0;
        if (overflow_out !== 1'b0) begin n_fail++; $display("FAIL pp_ovf: got %b want 0", overflow_out); end
        n_checks++;
        cyc = 0;
        while (got_q.size() < 16 && cyc < 60) begin tick(); cyc++; end
        if (got_q.size() !== 16) begin n_fail++; $display("FAIL pp_count: got %0d words want 16", got_q.size()); end
        n_checks++;
        for (int i = 0; i < 16 && i < got_q.size(); i++) begin
            if (got_q[i] !== {(i % 4 == 3), exp_q[i]}) begin
                n_fail++; $display("FAIL pp_word%0d: got %h want %h", i, got_q[i], {(i % 4 == 3), exp_q[i]});
            end
            n_checks++;
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        out_ready = 1'b0;
        for (int g = 1; g <= 4; g++) begin
            data_in_1 = mk(34'(g*16+9), 34'(g*16+10), 34'(g*16+11), 34'(g*16+12));
            p_s_flag_in = 1'b1;
            tick();
        end
        p_s_flag_in = 1'b0;
        out_ready = 1'b1;
        tick(); tick();
        if (data_out_1 !== 34'(16+11) || overflow_out !== 1'b1) begin
            n_fail++; $display("FAIL rmid_pre: data %h ovf %b want %h 1", data_out_1, overflow_out, 34'(16+11));
        end
        n_checks++;
        rst = 1'b1; p_s_flag_in = 1'b1;
        data_in_1 = mk(rand_word(), rand_word(), rand_word(), rand_word());
        tick();
        rst = 1'b0; p_s_flag_in = 1'b0;
        if (p_s_valid_out !== 1'b0 || data_out_1 !== '0 || busy_out !== 1'b0 ||
            overflow_out !== 1'b0 || p_s_last_out !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_clear: valid %b data %h busy %b ovf %b last %b want all 0",
                     p_s_valid_out, data_out_1, busy_out, overflow_out, p_s_last_out);
        end
        n_checks++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (p_s_valid_out !== 1'b0 || busy_out !== 1'b0) begin
                n_fail++; $display("FAIL rmid_ignored%0d: valid %b busy %b want 0 0", i, p_s_valid_out, busy_out);
            end
            n_checks++;
        end
    endtask

    task automatic test_random();
        logic [WORD_W-1:0] exp_q[$];
        logic [WORD_W-1:0] w[4];
        int sent, cyc;
        const int N = 24;
        apply_reset();
        stab_err = 0; sent = 0; cyc = 0;
        while (got_q.size() < 4*N && cyc < 3000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (sent < N && (sent - got_q.size()/4) < 2 && $urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 4; i++) begin
                    w[i] = rand_word();
                    exp_q.push_back(w[i]);
                end
                data_in_1 = mk(w[0], w[1], w[2], w[3]);
                p_s_flag_in = 1'b1;
                sent++;
            end else begin
                p_s_flag_in = 1'b0;
            end
            tick();
            cyc++;
        end
        p_s_flag_in = 1'b0; out_ready = 1'b1;
        repeat (6) tick();
        if (got_q.size() !== 4*N) begin n_fail++; $display("FAIL rnd_count: got %0d words want %0d", got_q.size(), 4*N); end
        n_checks++;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== {(i % 4 == 3), exp_q[i]}) begin
                n_fail++; $display("FAIL rnd_word%0d: got %h want %h", i, got_q[i], {(i % 4 == 3), exp_q[i]});
            end
            n_checks++;
        end
        if (overflow_out !== 1'b0 || stab_err !== 0) begin
            n_fail++; $display("FAIL rnd_flags: ovf %b stab_err %0d want 0 0", overflow_out, stab_err);
        end
        n_checks++;
    endtask

    initial begin
        rst = 1'b1; p_s_flag_in = 1'b0; out_ready = 1'b1; data_in_1 = '0;
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
